// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter with a small TX FIFO, configurable data
// width, optional parity and 1 or 2 stop bits. The baud rate comes from an
// integer divider of the system clock. Frames leave back-to-back whenever
// the FIFO still holds words at the end of a stop period.
module uart_tx_fifo #(
  parameter int CLK_DIV    = 4,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int CW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 send,
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow,
  output logic [CW-1:0]        fifo_count,
  output logic                 tx
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int DW = $clog2(CLK_DIV);
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = (STOP_BITS == 2);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4
  } state_t;

  state_t               state;

  // FIFO storage and pointers
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;

  // Bit timing
  logic [DW-1:0]        div_cnt;
  logic [BW-1:0]        bit_idx;
  logic                 stop_idx;

  // Frame payload
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;

  logic                 push;
  logic                 pop;
  logic                 fifo_empty;
  logic                 bit_end;
  logic                 frame_end;

  // Parity bit for a word: even parity is the plain XOR of the data bits,
  // odd parity its inverse so the total count of ones comes out odd.
  function automatic logic parity_of(input logic [DATA_BITS-1:0] w);
    if (PARITY == 1) begin
      return ~(^w);
    end
    return ^w;
  endfunction

  // ready looks only at the registered count, so a push that coincides with
  // a pop while full is still refused.
  assign ready      = (fifo_count < CW'(FIFO_DEPTH));
  assign busy       = (state != IDLE);
  assign fifo_empty = (fifo_count == '0);
  assign push       = send && ready;
  assign bit_end    = (div_cnt == DIV_LAST);
  assign frame_end  = (state == STOP) && bit_end && (stop_idx == STOP_LAST);
  // A word leaves the FIFO either from IDLE or on the last stop edge, which
  // is what lets consecutive frames abut without an idle bit.
  assign pop        = !fifo_empty && ((state == IDLE) || frame_end);

  // Write accepted words into FIFO storage
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= data;
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        fifo_count <= fifo_count + CW'(1);
      end else if (pop && !push) begin
        fifo_count <= fifo_count - CW'(1);
      end
      if (send && !ready) begin
        overflow <= 1'b1;
      end
    end
  end

  // Load the popped word with its parity, then shift it out LSB first
  always_ff @(posedge clock) begin
    if (pop) begin
      shreg   <= mem[rd_ptr];
      par_bit <= parity_of(mem[rd_ptr]);
    end else if (bit_end && ((state == START) || (state == DATA))) begin
      shreg <= shreg >> 1;
    end
  end

  // Frame sequencer: every non-idle state holds tx for one bit period
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state    <= IDLE;
      div_cnt  <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      tx       <= 1'b1;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state != IDLE) begin
        div_cnt <= bit_end ? '0 : div_cnt + DW'(1);
      end
      case (state)
        IDLE: begin
          if (pop) begin
            state <= START;
            tx    <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            state   <= DATA;
            tx      <= shreg[0];
            bit_idx <= '0;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_idx == BIT_LAST) begin
              stop_idx <= 1'b0;
              if (PARITY != 0) begin
                state <= PAR;
                tx    <= par_bit;
              end else begin
                state <= STOP;
                tx    <= 1'b1;
              end
            end else begin
              tx      <= shreg[0];
              bit_idx <= bit_idx + BW'(1);
            end
          end
        end
        PAR: begin
          if (bit_end) begin
            state    <= STOP;
            tx       <= 1'b1;
            stop_idx <= 1'b0;
          end
        end
        STOP: begin
          if (frame_end) begin
            done <= 1'b1;
            if (pop) begin
              state <= START;
              tx    <= 1'b0;
            end else begin
              state <= IDLE;
              tx    <= 1'b1;
            end
          end else if (bit_end) begin
            stop_idx <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed stimulus against two instances (even parity with
// defaults, and 7-bit odd parity with two stop bits), a queue-based frame
// model for the first instance, and literal expectations for key waveforms.
module tb_uart_tx_fifo;

  localparam int CLK_DIV = 4;
  localparam int DEPTH   = 4;
  localparam int FLEN    = 44;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;

  logic [7:0] data_a = 8'h00;
  logic       send_a = 1'b0;
  logic       ready_a, busy_a, done_a, ovf_a, tx_a;
  logic [2:0] cnt_a;

  logic [6:0] data_b = 7'h00;
  logic       send_b = 1'b0;
  logic       ready_b, busy_b, done_b, ovf_b, tx_b;
  logic [2:0] cnt_b;

  int compared = 0;
  int mismatched = 0;

  // Free-running system clock
  always #5 clock = ~clock;

  uart_tx_fifo #(
    .CLK_DIV(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) dut_a (
    .clock(clock), .reset_n(reset_n), .data(data_a), .send(send_a),
    .ready(ready_a), .busy(busy_a), .done(done_a), .overflow(ovf_a),
    .fifo_count(cnt_a), .tx(tx_a)
  );

  uart_tx_fifo #(
    .CLK_DIV(4), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)
  ) dut_b (
    .clock(clock), .reset_n(reset_n), .data(data_b), .send(send_b),
    .ready(ready_b), .busy(busy_b), .done(done_b), .overflow(ovf_b),
    .fifo_count(cnt_b), .tx(tx_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model of instance A: queue of accepted words plus the frame in flight
  logic [7:0] m_q[$];
  logic       m_active = 1'b0;
  int         m_t = 0;
  logic [7:0] m_cur = 8'h00;
  logic       m_done = 1'b0;
  logic       m_ovf = 1'b0;
  int         m_accepted = 0;
  logic       m_room;
  bit         chk_en = 1'b0;
  int         cyc = 0;

  // Line level at offset t of a frame carrying w: start, 8 data LSB first,
  // even parity, stop; idle line is high.
  function automatic logic exp_tx(input logic act, input int t, input logic [7:0] w);
    int b;
    if (!act) return 1'b1;
    b = t / CLK_DIV;
    if (b == 0) return 1'b0;
    if (b <= 8) return w[b-1];
    if (b == 9) return ^w;
    return 1'b1;
  endfunction

  // Advance the model on each rising edge from the inputs seen there
  always @(posedge clock) begin
    cyc++;
    if (!reset_n) begin
      m_q.delete();
      m_active = 1'b0;
      m_t      = 0;
      m_done   = 1'b0;
      m_ovf    = 1'b0;
    end else begin
      m_room = (m_q.size() < DEPTH);
      m_done = 1'b0;
      if (m_active) begin
        m_t++;
        if (m_t == FLEN) begin
          m_done   = 1'b1;
          m_active = 1'b0;
        end
      end
      if (!m_active && m_q.size() != 0) begin
        m_cur    = m_q.pop_front();
        m_active = 1'b1;
        m_t      = 0;
      end
      if (send_a) begin
        if (m_room) begin
          m_q.push_back(data_a);
          m_accepted++;
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
  end

  // Compare instance A against the model every cycle, away from the edge
  always @(negedge clock) begin
    if (chk_en) begin
      check("model_tx",         tx_a,   exp_tx(m_active, m_t, m_cur));
      check("model_busy",       busy_a, m_active);
      check("model_done",       done_a, m_done);
      check("model_overflow",   ovf_a,  m_ovf);
      check("model_fifo_count", cnt_a,  m_q.size());
      check("model_ready",      ready_a, (m_q.size() < DEPTH));
    end
  end

  // Record done pulses
  int done_times[$];
  int done_b_n = 0;
  always @(negedge clock) begin
    if (done_a === 1'b1) done_times.push_back(cyc);
    if (done_b === 1'b1) done_b_n++;
  end

  logic        s[FLEN];
  logic [10:0] exp_bits;
  int          nlow;
  int          acc0;
  int          d1;
  int          d2;

  initial begin
    // Reset
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    chk_en = 1'b1;
    check("rst_tx", tx_a, 1);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_overflow", ovf_a, 0);
    check("rst_ready", ready_a, 1);
    check("rst_fifo_count", cnt_a, 0);
    check("rst_b_tx", tx_b, 1);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    // Test 1: 0x40, even parity
    data_a = 8'h40; send_a = 1'b1;
    @(negedge clock);
    send_a = 1'b0;
    @(negedge clock);
    nlow = 0;
    for (int i = 0; i < FLEN; i++) begin
      s[i] = tx_a;
      if (busy_a !== 1'b1) nlow++;
      @(negedge clock);
    end
    check("t1_done_pulse", done_a, 1);
    check("t1_busy_low_samples", nlow, 0);
    exp_bits = 11'b11010000000;
    for (int b = 0; b < 11; b++) check($sformatf("t1_bit%0d", b), s[4*b+1], exp_bits[b]);
    @(negedge clock);
    check("t1_done_cleared", done_a, 0);
    check("t1_idle_busy", busy_a, 0);
    check("t1_done_count", done_times.size(), 1);

    // Test 2: 7-bit 0x7F, odd parity, 2 stop bits on instance B
    data_b = 7'h7F; send_b = 1'b1;
    @(negedge clock);
    send_b = 1'b0;
    @(negedge clock);
    nlow = 0;
    for (int i = 0; i < FLEN; i++) begin
      s[i] = tx_b;
      if (busy_b !== 1'b1) nlow++;
      @(negedge clock);
    end
    check("t2_done_pulse", done_b, 1);
    check("t2_busy_low_samples", nlow, 0);
    exp_bits = 11'b11011111110;
    for (int b = 0; b < 11; b++) check($sformatf("t2_bit%0d", b), s[4*b+1], exp_bits[b]);
    @(negedge clock);
    check("t2_done_count", done_b_n, 1);
    check("t2_idle_busy", busy_b, 0);

    // Test 3: three back-to-back frames
    done_times.delete();
    data_a = 8'h11; send_a = 1'b1;
    @(negedge clock);
    data_a = 8'h22;
    @(negedge clock);
    data_a = 8'h33;
    @(negedge clock);
    send_a = 1'b0;
    check("t3_count_peak", cnt_a, 2);
    repeat (3*FLEN + 10) @(negedge clock);
    check("t3_done_count", done_times.size(), 3);
    d1 = (done_times.size() >= 3) ? done_times[1] - done_times[0] : -1;
    d2 = (done_times.size() >= 3) ? done_times[2] - done_times[1] : -1;
    check("t3_gap1", d1, FLEN);
    check("t3_gap2", d2, FLEN);

    // Test 4: six pushes into a four-deep FIFO
    done_times.delete();
    for (int i = 0; i < 6; i++) begin
      data_a = 8'hA1 + 8'(i); send_a = 1'b1;
      @(negedge clock);
    end
    send_a = 1'b0;
    check("t4_overflow", ovf_a, 1);
    check("t4_ready_low", ready_a, 0);
    check("t4_count_full", cnt_a, 4);
    repeat (5*FLEN + 10) @(negedge clock);
    check("t4_done_count", done_times.size(), 5);
    check("t4_overflow_sticky", ovf_a, 1);

    // Test 5: reset in the middle of the data bits
    done_times.delete();
    data_a = 8'h5A; send_a = 1'b1;
    @(negedge clock);
    data_a = 8'hC3;
    @(negedge clock);
    data_a = 8'h0F;
    @(negedge clock);
    send_a = 1'b0;
    repeat (12) @(negedge clock);
    check("t5_pre_count", cnt_a, 2);
    check("t5_pre_busy", busy_a, 1);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    check("t5_tx_high", tx_a, 1);
    check("t5_count_clr", cnt_a, 0);
    check("t5_busy_clr", busy_a, 0);
    check("t5_overflow_clr", ovf_a, 0);
    repeat (100) @(negedge clock);
    check("t5_no_done", done_times.size(), 0);
    check("t5_line_idle", tx_a, 1);

    // Test 6: send held high for 150 cycles
    done_times.delete();
    acc0 = m_accepted;
    send_a = 1'b1;
    for (int i = 0; i < 150; i++) begin
      data_a = 8'(i) ^ 8'h5C;
      @(negedge clock);
    end
    send_a = 1'b0;
    check("t6_overflow", ovf_a, 1);
    for (int i = 0; i < 600 && !(busy_a === 1'b0 && cnt_a === 3'd0); i++) @(negedge clock);
    check("t6_drained", (busy_a === 1'b0 && cnt_a === 3'd0), 1);
    repeat (2) @(negedge clock);
    check("t6_accepted_model", m_accepted - acc0, 8);
    check("t6_done_count", done_times.size(), 8);

    chk_en = 1'b0;
    @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
